// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit: 64-bit HI/LO results tagged with the physical destination.
// Multiplies complete after MULT_LATENCY edges; divides use a 32-step restoring divider plus a sign-fix step.
module mult_div_unit #(
  parameter int unsigned MULT_LATENCY = 3,
  parameter int unsigned PREG_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [31:0]           in_src1,
  input  logic [31:0]           in_src2,
  input  logic [PREG_WIDTH-1:0] in_dst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_hi,
  output logic [31:0]           out_lo,
  output logic [PREG_WIDTH-1:0] out_dst,
  output logic                  busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    sgn_q;
  logic [DATA_W-1:0]       a_q;
  logic [DATA_W-1:0]       b_q;
  logic [PREG_WIDTH-1:0]   dst_q;
  logic [DATA_W-1:0]       quo_q;
  logic [DATA_W-1:0]       rem_q;
  logic [DATA_W-1:0]       dvs_q;
  logic                    qneg_q;
  logic                    rneg_q;
  logic                    dbz_q;

  logic                    accept;
  logic                    in_sgn;
  logic [DATA_W:0]         rem_sh;
  logic [DATA_W:0]         diff;
  logic                    ge;
  logic [DATA_W-1:0]       quo_nxt;
  logic [DATA_W-1:0]       rem_nxt;
  logic [2*DATA_W-1:0]     prod_q;
  logic [2*DATA_W-1:0]     prod_in;
  logic [DATA_W-1:0]       fix_lo;
  logic [DATA_W-1:0]       fix_hi;

  // Low 64 bits of a 64x64 product give the exact signed or unsigned 32x32 result.
  function automatic logic [2*DATA_W-1:0] mul_full(input logic sgn,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] ea;
    logic [2*DATA_W-1:0] eb;
    ea = {{DATA_W{sgn & a[DATA_W-1]}}, a};
    eb = {{DATA_W{sgn & b[DATA_W-1]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic sgn, input logic [DATA_W-1:0] x);
    return (sgn & x[DATA_W-1]) ? -x : x;
  endfunction

  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign in_sgn   = ~in_op[0];

  // One restoring-division step: shift in the next dividend bit and try subtracting.
  always_comb begin
    rem_sh  = {rem_q, quo_q[DATA_W-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    ge      = ~diff[DATA_W];
    rem_nxt = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quo_nxt = {quo_q[DATA_W-2:0], ge};
  end

  // Sign correction; divide-by-zero overrides the iterated result.
  always_comb begin
    prod_q  = mul_full(sgn_q, a_q, b_q);
    prod_in = mul_full(in_sgn, in_src1, in_src2);
    fix_lo  = dbz_q ? '1  : (qneg_q ? -quo_q : quo_q);
    fix_hi  = dbz_q ? a_q : (rneg_q ? -rem_q : rem_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sgn_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      dst_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dbz_q     <= 1'b0;
      out_valid <= 1'b0;
      out_hi    <= '0;
      out_lo    <= '0;
      out_dst   <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      sgn_q     <= in_sgn;
      a_q       <= in_src1;
      b_q       <= in_src2;
      dst_q     <= in_dst;
      out_valid <= 1'b0;
      case (in_op)
        OP_MULT, OP_MULTU: begin
          if (MULT_LATENCY == 1) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_hi    <= prod_in[2*DATA_W-1:DATA_W];
            out_lo    <= prod_in[DATA_W-1:0];
            out_dst   <= in_dst;
          end else begin
            state <= S_MUL;
            cnt   <= CNT_W'(MULT_LATENCY - 1);
          end
        end
        OP_DIV, OP_DIVU: begin
          state  <= S_DIV;
          cnt    <= CNT_W'(DATA_W - 1);
          quo_q  <= mag(in_sgn, in_src1);
          rem_q  <= '0;
          dvs_q  <= mag(in_sgn, in_src2);
          qneg_q <= in_sgn & (in_src1[DATA_W-1] ^ in_src2[DATA_W-1]);
          rneg_q <= in_sgn & in_src1[DATA_W-1];
          dbz_q  <= (in_src2 == '0);
        end
        default: begin
          state     <= S_DONE;
          out_valid <= 1'b1;
          out_hi    <= '0;
          out_lo    <= '0;
          out_dst   <= in_dst;
        end
      endcase
    end else begin
      case (state)
        S_MUL: begin
          if (cnt == '0) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_hi    <= prod_q[2*DATA_W-1:DATA_W];
            out_lo    <= prod_q[DATA_W-1:0];
            out_dst   <= dst_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          state     <= S_DONE;
          out_valid <= 1'b1;
          out_hi    <= fix_hi;
          out_lo    <= fix_lo;
          out_dst   <= dst_q;
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of single ops plus flush, reset and backpressure sequences.
module tb_mult_div_unit;

  localparam int unsigned L  = 3;
  localparam int unsigned PW = 6;
  localparam int unsigned DL = 33;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [31:0]   in_src1;
  logic [31:0]   in_src2;
  logic [PW-1:0] in_dst;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_hi;
  logic [31:0]   out_lo;
  logic [PW-1:0] out_dst;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_LATENCY(L), .PREG_WIDTH(PW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hi(out_hi), .out_lo(out_lo), .out_dst(out_dst), .busy(busy)
  );

  typedef struct {
    logic [2:0]    op;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [PW-1:0] dst;
    logic [31:0]   hi;
    logic [31:0]   lo;
    int            lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present one op from IDLE; returns just after the accept edge.
  task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [PW-1:0] d);
    in_op = op; in_src1 = a; in_src2 = b; in_dst = d; in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      chk({name, "_busy"}, 64'(busy), 64'd1);
      chk({name, "_in_ready_low"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_res(input string name, input int lat, input int exp_lat,
                           input logic [31:0] hi, input logic [31:0] lo, input logic [PW-1:0] d);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_hi"}, 64'(out_hi), 64'(hi));
    chk({name, "_lo"}, 64'(out_lo), 64'(lo));
    chk({name, "_dst"}, 64'(out_dst), 64'(d));
  endtask

  initial begin
    int lat;
    logic seen;

    vecs[0]  = '{op:3'd0, a:32'hFFFF_FFFE, b:32'd3,          dst:6'd5,  hi:32'hFFFF_FFFF, lo:32'hFFFF_FFFA, lat:L};
    vecs[1]  = '{op:3'd1, a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, dst:6'd1,  hi:32'hFFFF_FFFE, lo:32'h0000_0001, lat:L};
    vecs[2]  = '{op:3'd0, a:32'h8000_0000, b:32'h8000_0000, dst:6'd2,  hi:32'h4000_0000, lo:32'h0,         lat:L};
    vecs[3]  = '{op:3'd1, a:32'h1234_5678, b:32'h10,        dst:6'd3,  hi:32'h1,         lo:32'h2345_6780, lat:L};
    vecs[4]  = '{op:3'd2, a:32'hFFFF_FFF9, b:32'd2,          dst:6'd7,  hi:32'hFFFF_FFFF, lo:32'hFFFF_FFFD, lat:DL};
    vecs[5]  = '{op:3'd3, a:32'hFFFF_FFFF, b:32'd16,         dst:6'd8,  hi:32'hF,         lo:32'h0FFF_FFFF, lat:DL};
    vecs[6]  = '{op:3'd3, a:32'd100,       b:32'd0,          dst:6'd9,  hi:32'd100,       lo:32'hFFFF_FFFF, lat:DL};
    vecs[7]  = '{op:3'd2, a:32'h8000_0000, b:32'hFFFF_FFFF, dst:6'd10, hi:32'h0,         lo:32'h8000_0000, lat:DL};
    vecs[8]  = '{op:3'd5, a:32'h1234,      b:32'h5678,      dst:6'd11, hi:32'h0,         lo:32'h0,         lat:0};
    vecs[9]  = '{op:3'd2, a:32'd7,         b:32'hFFFF_FFFE, dst:6'd12, hi:32'd1,         lo:32'hFFFF_FFFD, lat:DL};
    vecs[10] = '{op:3'd2, a:32'hFFFF_FFF9, b:32'hFFFF_FFFE, dst:6'd13, hi:32'hFFFF_FFFF, lo:32'd3,         lat:DL};
    vecs[11] = '{op:3'd2, a:32'hFFFF_FFFB, b:32'd0,          dst:6'd14, hi:32'hFFFF_FFFB, lo:32'hFFFF_FFFF, lat:DL};
    vecs[12] = '{op:3'd3, a:32'd1000,      b:32'd7,          dst:6'd15, hi:32'd6,         lo:32'd142,       lat:DL};
    vecs[13] = '{op:3'd7, a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, dst:6'd63, hi:32'h0,         lo:32'h0,         lat:0};

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_src1 = '0; in_src2 = '0; in_dst = '0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_hi", 64'(out_hi), 64'd0);
    chk("rst_lo", 64'(out_lo), 64'd0);
    chk("rst_dst", 64'(out_dst), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      present(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst);
      wait_valid($sformatf("vec%0d", i), lat);
      check_res($sformatf("vec%0d", i), lat, vecs[i].lat, vecs[i].hi, vecs[i].lo, vecs[i].dst);
      consume($sformatf("vec%0d", i));
    end

    // Flush on the 10th divide iteration edge.
    present(3'd3, 32'd5000, 32'd3, 6'd20);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_div_busy", 64'(busy), 64'd0);
    chk("flush_div_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
    chk("flush_div_never_valid", 64'(seen), 64'd0);
    present(3'd0, 32'd6, 32'd7, 6'd21);
    wait_valid("post_flush_mult", lat);
    check_res("post_flush_mult", lat, L, 32'd0, 32'd42, 6'd21);
    consume("post_flush_mult");

    // Flush while a result waits unconsumed.
    present(3'd1, 32'd2, 32'd2, 6'd22);
    wait_valid("done_flush", lat);
    chk("done_flush_valid_before", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    repeat (5) begin seen |= out_valid | busy; @(posedge clk); #1; end
    chk("done_flush_dropped", 64'(seen), 64'd0);

    // Reset in the middle of a divide.
    present(3'd2, 32'hFFFF_FF00, 32'd9, 6'd23);
    repeat (5) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_hi", 64'(out_hi), 64'd0);
    chk("midrst_lo", 64'(out_lo), 64'd0);
    chk("midrst_dst", 64'(out_dst), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Backpressure, then handshake and accept on the same edge.
    present(3'd0, 32'd3, 32'd5, 6'd9);
    wait_valid("bp", lat);
    check_res("bp", lat, L, 32'd0, 32'd15, 6'd9);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_hi", 64'(out_hi), 64'd0);
      chk("bp_hold_lo", 64'(out_lo), 64'd15);
      chk("bp_hold_dst", 64'(out_dst), 64'd9);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    in_op = 3'd1; in_src1 = 32'd2; in_src2 = 32'd3; in_dst = 6'd11; in_valid = 1'b1;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_valid_drop", 64'(out_valid), 64'd0);
    wait_valid("b2b", lat);
    check_res("b2b", lat, L, 32'd0, 32'd6, 6'd11);
    consume("b2b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
